// File: rtl/rate_pkg.sv
// Shared constants for the programmable rate dividers.
// Also used directly by single-channel divider users.
package rate_pkg;

  localparam int   RATE_WIDTH    = 28;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Channel-index width; a single-channel bank still gets a 1-bit index.
  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rate_divider_bank_if.sv
// Configuration/strobe bundle between a rate divider bank and its controller.
interface rate_divider_bank_if #(
  parameter int WIDTH    = rate_pkg::RATE_WIDTH,
  parameter int CHANNELS = 4
);

  localparam int CH_W = rate_pkg::ch_idx_width(CHANNELS);

  logic [CHANNELS-1:0] enable;
  logic                load;
  logic [CH_W-1:0]     load_ch;
  logic [WIDTH-1:0]    load_max;
  logic                load_mode;
  logic                sync;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] armed;

  modport master (
    output enable, load, load_ch, load_max, load_mode, sync,
    input  tick, armed
  );

  modport slave (
    input  enable, load, load_ch, load_max, load_mode, sync,
    output tick, armed
  );

endinterface

// File: rtl/rate_channel.sv
// One tick-generator slice: counter, terminal value, mode and armed flag.
// Counts enabled clocks up to max and emits a registered one-cycle tick.
module rate_channel
  import rate_pkg::*;
#(
  parameter int               WIDTH     = RATE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_MAX = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load_hit,
  input  logic [WIDTH-1:0] load_max,
  input  logic             load_mode,
  input  logic             sync,
  input  logic             enable,
  output logic             tick,
  output logic             armed
);

  logic [WIDTH-1:0] counter_reg, counter_next;
  logic [WIDTH-1:0] max_reg, max_next;
  logic             mode_reg, mode_next;
  logic             armed_reg, armed_next;
  logic             tick_reg, tick_next;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      counter_reg <= '0;
      max_reg     <= RESET_MAX;
      mode_reg    <= MODE_PERIODIC;
      armed_reg   <= 1'b1;
      tick_reg    <= 1'b0;
    end else begin
      counter_reg <= counter_next;
      max_reg     <= max_next;
      mode_reg    <= mode_next;
      armed_reg   <= armed_next;
      tick_reg    <= tick_next;
    end
  end

  // Tick is checked before increment, so max = all-ones never wraps the counter.
  always_comb begin
    counter_next = counter_reg;
    max_next     = max_reg;
    mode_next    = mode_reg;
    armed_next   = armed_reg;
    tick_next    = 1'b0;
    if (load_hit) begin
      max_next     = load_max;
      mode_next    = load_mode;
      counter_next = '0;
      armed_next   = 1'b1;
    end else if (sync) begin
      counter_next = '0;
    end else if (!enable) begin
      counter_next = counter_reg;
    end else if (!armed_reg) begin
      counter_next = '0;
    end else if (counter_reg == max_reg) begin
      tick_next    = 1'b1;
      counter_next = '0;
      if (mode_reg == MODE_ONESHOT) begin
        armed_next = 1'b0;
      end
    end else begin
      counter_next = counter_reg + WIDTH'(1);
    end
  end

  assign tick  = tick_reg;
  assign armed = armed_reg;

endmodule

// File: rtl/rate_divider_bank.sv
// Bank of independent programmable tick generators with shared load port
// and global phase sync; this level only decodes the load channel index.
module rate_divider_bank
  import rate_pkg::*;
#(
  parameter int               WIDTH     = RATE_WIDTH,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_MAX = '0
) (
  input  logic                clock,
  input  logic                clear,
  rate_divider_bank_if.slave  bus
);

  localparam int CH_W = ch_idx_width(CHANNELS);

  logic [CHANNELS-1:0] load_hit;
  logic [CHANNELS-1:0] tick_w;
  logic [CHANNELS-1:0] armed_w;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // Indices at or beyond CHANNELS match no slice, so such loads are dropped.
      assign load_hit[gi] = bus.load && (bus.load_ch == CH_W'(gi));

      rate_channel #(
        .WIDTH     (WIDTH),
        .RESET_MAX (RESET_MAX)
      ) u_channel (
        .clock     (clock),
        .clear     (clear),
        .load_hit  (load_hit[gi]),
        .load_max  (bus.load_max),
        .load_mode (bus.load_mode),
        .sync      (bus.sync),
        .enable    (bus.enable[gi]),
        .tick      (tick_w[gi]),
        .armed     (armed_w[gi])
      );
    end
  endgenerate

  assign bus.tick  = tick_w;
  assign bus.armed = armed_w;

endmodule

// File: tb/tb_rate_divider_bank.sv
// Scoreboard bench: expected tick/armed per cycle queued from closed-form
// period formulas, then popped and compared one cycle at a time.
module tb_rate_divider_bank;
  import rate_pkg::*;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  rate_divider_bank_if #(.WIDTH(28), .CHANNELS(4)) bus ();
  rate_divider_bank_if #(.WIDTH(8),  .CHANNELS(3)) bus3 ();

  rate_divider_bank #(.WIDTH(28), .CHANNELS(4), .RESET_MAX(28'd0)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  rate_divider_bank #(.WIDTH(8), .CHANNELS(3), .RESET_MAX(8'd2)) dut3 (
    .clock (clock),
    .clear (clear),
    .bus   (bus3)
  );

  typedef struct {
    logic [3:0] tick;
    logic [3:0] mask;
    logic [3:0] armed;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic edge_wait();
    @(posedge clock);
    #1;
  endtask

  task automatic load_cfg(input int ch, input logic [27:0] m, input logic mode);
    bus.load      = 1'b1;
    bus.load_ch   = 2'(ch);
    bus.load_max  = m;
    bus.load_mode = mode;
    edge_wait();
    bus.load      = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    bus.enable = '0; bus.load = 1'b0; bus.load_ch = '0; bus.load_max = '0;
    bus.load_mode = 1'b0; bus.sync = 1'b0;
    bus3.enable = '0; bus3.load = 1'b0; bus3.load_ch = '0; bus3.load_max = '0;
    bus3.load_mode = 1'b0; bus3.sync = 1'b0;
    #12;
    n_checks++;
    if (bus.tick !== 4'h0) begin
      n_fail++; $display("FAIL reset_tick got=%b want=0000", bus.tick);
    end
    n_checks++;
    if (bus.armed !== 4'hF) begin
      n_fail++; $display("FAIL reset_armed got=%b want=1111", bus.armed);
    end
    n_checks++;
    if (bus3.armed !== 3'b111 || bus3.tick !== 3'b000) begin
      n_fail++; $display("FAIL reset_dut3 tick=%b armed=%b want tick=000 armed=111", bus3.tick, bus3.armed);
    end
    edge_wait();
    clear = 1'b1;
    edge_wait();
    n_checks++;
    if (bus.tick !== 4'h0) begin
      n_fail++; $display("FAIL reset_idle_tick got=%b want=0000", bus.tick);
    end
  endtask

  // ch0 max=3; enable dropped for edges 6 and 7 so the count must hold there.
  task automatic test_periodic();
    exp_t e;
    int   cnt = 0;
    logic en;
    for (int k = 0; k <= 16; k++) begin
      en = !(k == 6 || k == 7);
      if (k > 0 && en) cnt++;
      e.tick = '0; e.tick[0] = (k > 0) && en && (cnt % 4 == 0);
      e.mask = 4'b0001; e.armed = 4'hF;
      exp_q.push_back(e);
    end
    bus.enable = 4'b0001;
    load_cfg(0, 28'd3, MODE_PERIODIC);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) edge_wait();
      e = exp_q.pop_front();
      n_checks++;
      if ((bus.tick & e.mask) !== (e.tick & e.mask)) begin
        n_fail++; $display("FAIL periodic k=%0d tick=%b want=%b", k, bus.tick & e.mask, e.tick);
      end
      n_checks++;
      if (bus.armed !== e.armed) begin
        n_fail++; $display("FAIL periodic_armed k=%0d got=%b want=%b", k, bus.armed, e.armed);
      end
      bus.enable[0] = !((k + 1) == 6 || (k + 1) == 7);
    end
  endtask

  task automatic test_max0();
    exp_t e;
    for (int k = 0; k <= 8; k++) begin
      e.tick = '0; e.tick[1] = (k > 0) && (k != 4);
      e.mask = 4'b0010; e.armed = 4'hF;
      exp_q.push_back(e);
    end
    bus.enable = 4'b0011;
    load_cfg(1, 28'd0, MODE_PERIODIC);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) edge_wait();
      e = exp_q.pop_front();
      n_checks++;
      if ((bus.tick & e.mask) !== (e.tick & e.mask)) begin
        n_fail++; $display("FAIL max0 k=%0d tick=%b want=%b", k, bus.tick & e.mask, e.tick);
      end
      bus.enable[1] = ((k + 1) != 4);
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k <= ((pass == 0) ? 56 : 8); k++) begin
        e.tick = '0; e.tick[2] = (k == 6);
        e.mask = 4'b0100; e.armed = (k < 6) ? 4'hF : 4'hB;
        exp_q.push_back(e);
      end
      bus.enable = 4'b0111;
      load_cfg(2, 28'd5, MODE_ONESHOT);
      for (int k = 0; k <= ((pass == 0) ? 56 : 8); k++) begin
        if (k > 0) edge_wait();
        e = exp_q.pop_front();
        n_checks++;
        if ((bus.tick & e.mask) !== (e.tick & e.mask)) begin
          n_fail++; $display("FAIL oneshot pass=%0d k=%0d tick=%b want=%b", pass, k, bus.tick & e.mask, e.tick);
        end
        n_checks++;
        if (bus.armed !== e.armed) begin
          n_fail++; $display("FAIL oneshot_armed pass=%0d k=%0d got=%b want=%b", pass, k, bus.armed, e.armed);
        end
      end
    end
  endtask

  // Second phase collides a load of ch0 (max=1) with sync in the same cycle.
  task automatic test_sync();
    exp_t e;
    bus.enable = 4'b1001;
    load_cfg(3, 28'd7, MODE_PERIODIC);
    load_cfg(0, 28'd3, MODE_PERIODIC);
    repeat (5) edge_wait();
    for (int phase = 0; phase < 2; phase++) begin
      for (int k = 0; k <= 16; k++) begin
        e.tick = '0;
        e.tick[0] = (k > 0) && (k % ((phase == 0) ? 4 : 2) == 0);
        e.tick[3] = (k > 0) && (k % 8 == 0);
        e.mask = 4'b1001; e.armed = 4'hB;
        exp_q.push_back(e);
      end
      bus.sync = 1'b1;
      if (phase == 1) begin
        bus.load = 1'b1; bus.load_ch = 2'd0; bus.load_max = 28'd1; bus.load_mode = MODE_PERIODIC;
      end
      edge_wait();
      bus.sync = 1'b0;
      bus.load = 1'b0;
      for (int k = 0; k <= 16; k++) begin
        if (k > 0) edge_wait();
        e = exp_q.pop_front();
        n_checks++;
        if ((bus.tick & e.mask) !== (e.tick & e.mask)) begin
          n_fail++; $display("FAIL sync phase=%0d k=%0d tick=%b want=%b", phase, k, bus.tick & e.mask, e.tick);
        end
      end
    end
  endtask

  // dut3 has 3 channels, so load_ch=3 addresses nothing; reset max is 2.
  task automatic test_bad_index();
    exp_t e;
    for (int k = 1; k <= 9; k++) begin
      e.tick = (k % 3 == 0) ? 4'b0111 : 4'b0000;
      e.mask = 4'b0111; e.armed = 4'b0111;
      exp_q.push_back(e);
    end
    bus3.enable = 3'b111;
    bus3.load = 1'b1; bus3.load_ch = 2'd3; bus3.load_max = 8'd0; bus3.load_mode = MODE_ONESHOT;
    for (int k = 1; k <= 9; k++) begin
      edge_wait();
      e = exp_q.pop_front();
      n_checks++;
      if ({1'b0, bus3.tick} !== e.tick) begin
        n_fail++; $display("FAIL bad_index k=%0d tick=%b want=%b", k, bus3.tick, e.tick[2:0]);
      end
      n_checks++;
      if ({1'b0, bus3.armed} !== e.armed) begin
        n_fail++; $display("FAIL bad_index_armed k=%0d got=%b want=%b", k, bus3.armed, e.armed[2:0]);
      end
      if (k == 2) bus3.load = 1'b0;
    end
  endtask

  task automatic test_wide_max();
    exp_t e;
    for (int k = 0; k <= 260; k++) begin
      e.tick = '0; e.tick[1] = (k == 256);
      e.mask = 4'b0010; e.armed = 4'b0111;
      exp_q.push_back(e);
    end
    bus3.load = 1'b1; bus3.load_ch = 2'd1; bus3.load_max = 8'hFF; bus3.load_mode = MODE_PERIODIC;
    edge_wait();
    bus3.load = 1'b0;
    for (int k = 0; k <= 260; k++) begin
      if (k > 0) edge_wait();
      e = exp_q.pop_front();
      n_checks++;
      if (({1'b0, bus3.tick} & e.mask) !== (e.tick & e.mask)) begin
        n_fail++; $display("FAIL wide_max k=%0d tick=%b want=%b", k, bus3.tick[1], e.tick[1]);
      end
    end
  endtask

  task automatic test_reset_midcount();
    exp_t e;
    bus.enable = 4'hF;
    repeat (2) edge_wait();
    n_checks++;
    if (bus.tick[1] !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_tick1 got=%b want=1", bus.tick[1]);
    end
    #3;
    clear = 1'b0;
    #1;
    n_checks++;
    if (bus.tick !== 4'h0) begin
      n_fail++; $display("FAIL async_reset_tick got=%b want=0000", bus.tick);
    end
    n_checks++;
    if (bus.armed !== 4'hF) begin
      n_fail++; $display("FAIL async_reset_armed got=%b want=1111", bus.armed);
    end
    for (int k = 1; k <= 4; k++) begin
      e.tick = 4'hF; e.mask = 4'hF; e.armed = 4'hF;
      exp_q.push_back(e);
    end
    edge_wait();
    clear = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      edge_wait();
      e = exp_q.pop_front();
      n_checks++;
      if (bus.tick !== e.tick) begin
        n_fail++; $display("FAIL post_reset k=%0d tick=%b want=%b", k, bus.tick, e.tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_max0();
    test_oneshot();
    test_sync();
    test_bad_index();
    test_wide_max();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
